// File: rtl/param_bus_master.sv
// Second bus master that bursts parameter words into, or reads them back out of, the
// ParamIntf address/data register pair of a reconfigurable-logic wrapper.
module param_bus_master #(
  parameter logic [13:0] BaseAddr   = 14'h0188,
  parameter bit          AutoInc    = 1'b1,
  parameter int          CountWidth = 4
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Start_i,
  input  logic                  Read_i,
  input  logic [15:0]           ParamAddr_i,
  input  logic [CountWidth-1:0] Count_i,
  input  logic [15:0]           WrData_i,
  input  logic                  WrValid_i,
  output logic                  WrReady_o,
  output logic [15:0]           RdData_o,
  output logic                  RdValid_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [13:0]           PerAddr_o,
  output logic [15:0]           PerDOut_o,
  output logic [1:0]            PerWr_o,
  output logic                  PerEn_o,
  input  logic [15:0]           PerDIn_i
);

  typedef enum logic [2:0] {
    IDLE, SET_ADDR, WAIT_WR, WRITE, READ, READ_CAP, DONE
  } stateT;

  localparam logic [13:0] DataAddr = BaseAddr + 14'd1;

  stateT                 state, nextState;
  logic [15:0]           paramAddr, nextParamAddr;
  logic [CountWidth-1:0] remaining, nextRemaining;
  logic                  isRead, nextIsRead;
  logic                  lastWord;

  logic [15:0] nextRdData;
  logic        nextRdValid, nextWrReady, nextBusy, nextDone, nextPerEn;
  logic [1:0]  nextPerWr;
  logic [13:0] nextPerAddr;
  logic [15:0] nextPerDOut;

  assign lastWord = (remaining == CountWidth'(1));

  // Next state first, then every output is decoded from the state being entered so the
  // registered outputs line up exactly with the cycle that state occupies.
  always_comb begin
    nextState     = state;
    nextParamAddr = paramAddr;
    nextRemaining = remaining;
    nextIsRead    = isRead;
    nextRdData    = RdData_o;
    nextRdValid   = 1'b0;
    nextWrReady   = 1'b0;
    nextBusy      = 1'b0;
    nextDone      = 1'b0;
    nextPerEn     = 1'b0;
    nextPerWr     = 2'b00;
    nextPerAddr   = '0;
    nextPerDOut   = '0;

    case (state)
      IDLE: begin
        if (Start_i) begin
          if (Count_i != '0) begin
            nextIsRead    = Read_i;
            nextParamAddr = ParamAddr_i;
            nextRemaining = Count_i;
            nextState     = SET_ADDR;
          end else begin
            nextState = DONE;
          end
        end
      end
      SET_ADDR: nextState = isRead ? READ : WAIT_WR;
      WAIT_WR: begin
        if (WrValid_i) nextState = WRITE;
      end
      READ: nextState = READ_CAP;
      WRITE, READ_CAP: begin
        nextRemaining = remaining - CountWidth'(1);
        nextParamAddr = paramAddr + 16'd1;
        if (lastWord)     nextState = DONE;
        else if (AutoInc) nextState = isRead ? READ : WAIT_WR;
        else              nextState = SET_ADDR;
        if (state == READ_CAP) begin
          nextRdValid = 1'b1;
          nextRdData  = PerDIn_i;
        end
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase

    case (nextState)
      SET_ADDR: begin
        nextPerEn   = 1'b1;
        nextPerWr   = 2'b11;
        nextPerAddr = BaseAddr;
        nextPerDOut = nextParamAddr;
      end
      WRITE: begin
        nextPerEn   = 1'b1;
        nextPerWr   = 2'b11;
        nextPerAddr = DataAddr;
        nextPerDOut = WrData_i;
        nextWrReady = 1'b1;
      end
      READ: begin
        nextPerEn   = 1'b1;
        nextPerAddr = DataAddr;
      end
      DONE: nextDone = 1'b1;
      default: ;
    endcase

    nextBusy = (nextState != IDLE) && (nextState != DONE);
  end

  // State, burst bookkeeping and all outputs; reset abandons any burst without a Done.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state     <= IDLE;
      paramAddr <= '0;
      remaining <= '0;
      isRead    <= 1'b0;
      RdData_o  <= '0;
      RdValid_o <= 1'b0;
      WrReady_o <= 1'b0;
      Busy_o    <= 1'b0;
      Done_o    <= 1'b0;
      PerEn_o   <= 1'b0;
      PerWr_o   <= 2'b00;
      PerAddr_o <= '0;
      PerDOut_o <= '0;
    end else begin
      state     <= nextState;
      paramAddr <= nextParamAddr;
      remaining <= nextRemaining;
      isRead    <= nextIsRead;
      RdData_o  <= nextRdData;
      RdValid_o <= nextRdValid;
      WrReady_o <= nextWrReady;
      Busy_o    <= nextBusy;
      Done_o    <= nextDone;
      PerEn_o   <= nextPerEn;
      PerWr_o   <= nextPerWr;
      PerAddr_o <= nextPerAddr;
      PerDOut_o <= nextPerDOut;
    end
  end

endmodule

// File: tb/tb_param_bus_master.sv
// Bench for param_bus_master: instance 0 uses AutoInc=1, instance 1 AutoInc=0, each
// talking to a behavioural ParamIntf slave; bursts are checked against a burst-level model.
module tb_param_bus_master;
  localparam logic [13:0] BASE = 14'h0188;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic        readDir [2];
  logic [15:0] paramAddr [2];
  logic [3:0]  count [2];
  logic [15:0] wrData [2];
  logic        wrValid [2];
  logic        wrReady [2];
  logic [15:0] rdData [2];
  logic        rdValid [2];
  logic        busy [2];
  logic        done [2];
  logic [13:0] perAddr [2];
  logic [15:0] perDOut [2];
  logic [1:0]  perWr [2];
  logic        perEn [2];
  logic [15:0] perDIn [2];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cyc        = 0;
  int act        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_bus_master #(.BaseAddr(BASE), .AutoInc(1'b1), .CountWidth(4)) dutInc (
    .Clk_i(clk), .Reset_i(reset), .Start_i(start[0]), .Read_i(readDir[0]),
    .ParamAddr_i(paramAddr[0]), .Count_i(count[0]), .WrData_i(wrData[0]),
    .WrValid_i(wrValid[0]), .WrReady_o(wrReady[0]), .RdData_o(rdData[0]),
    .RdValid_o(rdValid[0]), .Busy_o(busy[0]), .Done_o(done[0]), .PerAddr_o(perAddr[0]),
    .PerDOut_o(perDOut[0]), .PerWr_o(perWr[0]), .PerEn_o(perEn[0]), .PerDIn_i(perDIn[0]));

  param_bus_master #(.BaseAddr(BASE), .AutoInc(1'b0), .CountWidth(4)) dutNoInc (
    .Clk_i(clk), .Reset_i(reset), .Start_i(start[1]), .Read_i(readDir[1]),
    .ParamAddr_i(paramAddr[1]), .Count_i(count[1]), .WrData_i(wrData[1]),
    .WrValid_i(wrValid[1]), .WrReady_o(wrReady[1]), .RdData_o(rdData[1]),
    .RdValid_o(rdValid[1]), .Busy_o(busy[1]), .Done_o(done[1]), .PerAddr_o(perAddr[1]),
    .PerDOut_o(perDOut[1]), .PerWr_o(perWr[1]), .PerEn_o(perEn[1]), .PerDIn_i(perDIn[1]));

  // ParamIntf slave: unwritten cells read back a fixed hash of their address.
  logic [15:0] slaveMem [2][65536];
  bit          slaveWritten [2][65536];
  logic [15:0] slaveAddr [2];

  function automatic logic [15:0] seedWord(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5AC3;
  endfunction

  function automatic logic [15:0] slaveValue(input int u, input logic [15:0] a);
    return slaveWritten[u][a] ? slaveMem[u][a] : seedWord(a);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (perEn[u] && perWr[u] == 2'b11 && perAddr[u] == BASE) begin
        slaveAddr[u] <= perDOut[u];
      end else if (perEn[u] && perWr[u] == 2'b11 && perAddr[u] == BASE + 14'd1) begin
        slaveMem[u][slaveAddr[u]]     <= perDOut[u];
        slaveWritten[u][slaveAddr[u]] <= 1'b1;
        if (u == 0) slaveAddr[u] <= slaveAddr[u] + 16'd1;
      end else if (perEn[u] && perWr[u] == 2'b00 && perAddr[u] == BASE + 14'd1) begin
        perDIn[u] <= slaveValue(u, slaveAddr[u]);
        if (u == 0) slaveAddr[u] <= slaveAddr[u] + 16'd1;
      end
    end
  end

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [1:0]  wr;
  } busEvT;

  busEvT       busQ [$];
  int          busCycQ [$];
  logic [15:0] rdQ [$];
  int          rdCycQ [$];
  int          doneCycQ [$];
  int          readyCount = 0;
  int          idleDirty = 0;
  int          busyAtDone = 0;

  always @(negedge clk) begin
    if (perEn[act]) begin
      busQ.push_back({perAddr[act], perDOut[act], perWr[act]});
      busCycQ.push_back(cyc);
    end else if (perAddr[act] != 14'd0 || perDOut[act] != 16'd0 || perWr[act] != 2'd0) begin
      idleDirty++;
    end
    if (rdValid[act]) begin
      rdQ.push_back(rdData[act]);
      rdCycQ.push_back(cyc);
    end
    if (done[act]) begin
      doneCycQ.push_back(cyc);
      if (busy[act]) busyAtDone++;
    end
    if (wrReady[act]) readyCount++;
  end

  function automatic logic [31:0] ctlWord(input int u);
    return {11'd0, wrReady[u], rdValid[u], busy[u], done[u], perEn[u], perWr[u], perAddr[u]};
  endfunction

  function automatic logic [31:0] dataWord(input int u);
    return {perDOut[u], rdData[u]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [15:0] presetWords [$];

  task automatic applyStimulus(input int u, input bit isRead, input logic [15:0] addr,
                               input int n, input int stallAfter, input int stallLen,
                               input bit poke, input int resetAtEvent);
    logic [15:0] words [$];
    logic [15:0] expRd [$];
    busEvT       expBus [$];
    int          expStrobe [$];
    int          bus0, rd0, done0, ready0, dirty0, busyDone0, idx;
    bit          aborted;
    string       tag;

    tag = $sformatf("u%0d %s @%h n%0d", u, isRead ? "rd" : "wr", addr, n);
    act = u;
    for (int i = 0; i < n; i++) begin
      words.push_back(presetWords.size() != 0 ? presetWords.pop_front() : 16'($urandom));
      expRd.push_back(slaveValue(u, addr + 16'(i)));
    end
    if (n != 0) expBus.push_back({BASE, addr, 2'b11});
    for (int i = 0; i < n; i++) begin
      if (i != 0 && u == 1) expBus.push_back({BASE, addr + 16'(i), 2'b11});
      expStrobe.push_back(expBus.size());
      expBus.push_back(isRead ? {BASE + 14'd1, 16'h0000, 2'b00}
                              : {BASE + 14'd1, words[i], 2'b11});
    end

    @(negedge clk);
    bus0 = busQ.size(); rd0 = rdQ.size(); done0 = doneCycQ.size();
    ready0 = readyCount; dirty0 = idleDirty; busyDone0 = busyAtDone;
    start[u] = 1'b1; readDir[u] = isRead; paramAddr[u] = addr; count[u] = 4'(n);
    @(negedge clk);
    start[u] = 1'b0; readDir[u] = ~isRead; paramAddr[u] = 16'($urandom); count[u] = 4'($urandom);
    checkOutput({tag, " busyRise"}, 32'(busy[u]), 32'(n != 0));

    aborted = 1'b0;
    fork
      begin
        if (!isRead) begin
          for (int i = 0; i < n && !aborted; i++) begin
            if (i == stallAfter && stallLen > 0) begin
              wrValid[u] = 1'b0;
              repeat (stallLen) @(negedge clk);
            end
            wrValid[u] = 1'b1;
            wrData[u]  = words[i];
            for (int k = 0; k < TIMEOUT && !aborted; k++) begin
              @(negedge clk);
              if (wrReady[u]) break;
            end
          end
        end
        wrValid[u] = 1'b0;
      end
      begin
        if (poke && n != 0 && resetAtEvent == 0) begin
          @(negedge clk);
          start[u] = 1'b1; count[u] = 4'd5; readDir[u] = ~isRead;
          @(negedge clk);
          start[u] = 1'b0;
        end
        for (int k = 0; k < TIMEOUT; k++) begin
          if (resetAtEvent != 0 && busQ.size() - bus0 >= resetAtEvent) break;
          if (resetAtEvent == 0 && doneCycQ.size() != done0) break;
          @(negedge clk);
          #1;
        end
        if (resetAtEvent != 0) begin
          reset   = 1'b1;
          aborted = 1'b1;
          @(negedge clk);
          checkOutput({tag, " resetCtl"}, ctlWord(u), 32'd0);
          checkOutput({tag, " resetData"}, dataWord(u), 32'd0);
          reset = 1'b0;
        end
      end
    join

    repeat (4) @(negedge clk);
    #1;
    if (resetAtEvent != 0) begin
      checkOutput({tag, " noDoneAfterReset"}, doneCycQ.size() - done0, 32'd0);
      checkOutput({tag, " busAfterReset"}, busQ.size() - bus0, resetAtEvent);
      return;
    end

    checkOutput({tag, " busLen"}, busQ.size() - bus0, expBus.size());
    for (int i = 0; i < expBus.size() && bus0 + i < busQ.size(); i++)
      checkOutput($sformatf("%s bus[%0d]", tag, i), busQ[bus0 + i], expBus[i]);
    checkOutput({tag, " doneCount"}, doneCycQ.size() - done0, 32'd1);
    checkOutput({tag, " busyAtDone"}, busyAtDone - busyDone0, 32'd0);
    checkOutput({tag, " idleBusZero"}, idleDirty - dirty0, 32'd0);

    if (isRead) begin
      checkOutput({tag, " rdCount"}, rdQ.size() - rd0, n);
      for (int i = 0; i < n && rd0 + i < rdQ.size(); i++) begin
        checkOutput($sformatf("%s rdData[%0d]", tag, i), 32'(rdQ[rd0 + i]), 32'(expRd[i]));
        idx = bus0 + expStrobe[i];
        if (idx < busCycQ.size())
          checkOutput($sformatf("%s rdLatency[%0d]", tag, i), rdCycQ[rd0 + i] - busCycQ[idx], 32'd2);
      end
      if (n != 0 && rdCycQ.size() > rd0 && doneCycQ.size() > done0)
        checkOutput({tag, " lastRdWithDone"}, rdCycQ[rdCycQ.size() - 1], doneCycQ[done0]);
    end else begin
      checkOutput({tag, " wrReadyCount"}, readyCount - ready0, n);
      if (n != 0 && busCycQ.size() > bus0 && doneCycQ.size() > done0)
        checkOutput({tag, " doneAfterLastWr"}, doneCycQ[done0] - busCycQ[busCycQ.size() - 1], 32'd1);
      for (int i = 0; i < n; i++)
        checkOutput($sformatf("%s slaveMem[%0d]", tag, i), 32'(slaveValue(u, addr + 16'(i))),
                    32'(words[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; readDir[u] = 1'b0; paramAddr[u] = '0;
      count[u] = '0; wrData[u] = '0; wrValid[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset ctl u%0d", u), ctlWord(u), 32'd0);
      checkOutput($sformatf("reset data u%0d", u), dataWord(u), 32'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    presetWords = '{16'h1111, 16'h2222, 16'h3333};
    applyStimulus(0, 1'b0, 16'h0002, 3, -1, 0, 1'b0, 0);
    presetWords = '{16'h1111, 16'h2222, 16'h3333};
    applyStimulus(1, 1'b0, 16'h0002, 3, -1, 0, 1'b0, 0);

    presetWords = '{16'h00A5, 16'h1234};
    applyStimulus(0, 1'b0, 16'h0000, 2, -1, 0, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0000, 2, -1, 0, 1'b0, 0);
    presetWords = '{16'h00A5, 16'h1234};
    applyStimulus(1, 1'b0, 16'h0000, 2, -1, 0, 1'b0, 0);
    applyStimulus(1, 1'b1, 16'h0000, 2, -1, 0, 1'b0, 0);

    applyStimulus(0, 1'b0, 16'h0010, 4, 1, 5, 1'b0, 0);
    applyStimulus(1, 1'b0, 16'h0010, 4, 1, 5, 1'b0, 0);

    applyStimulus(0, 1'b0, 16'h0040, 0, -1, 0, 1'b0, 0);
    applyStimulus(1, 1'b1, 16'h0040, 0, -1, 0, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0020, 4, -1, 0, 1'b1, 0);
    applyStimulus(1, 1'b0, 16'h0030, 3, -1, 0, 1'b1, 0);

    applyStimulus(1, 1'b0, 16'hFFFE, 4, -1, 0, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'hFFFE, 4, -1, 0, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0100, 15, -1, 0, 1'b0, 0);
    applyStimulus(1, 1'b0, 16'h0200, 15, 7, 2, 1'b0, 0);

    applyStimulus(0, 1'b0, 16'h0002, 3, -1, 0, 1'b0, 3);
    applyStimulus(0, 1'b0, 16'h0002, 3, -1, 0, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle budget exceeded, %0d of %0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/param_bus_master.md
Name: param_bus_master

Overview:
- Peripheral-bus initiator that drives the ParamIntf register pair of a reconfigurable-logic wrapper from the other end of the bus.
- Bursts parameter writes (thresholds, counter presets, I2C divider) into the wrapper and reads back parameter-read words (sensor value, I2C error flags).
- Sits between a local controller/boot sequencer and the openMSP430-style peripheral bus, as a second bus master in test and boot configurations.
- ParamIntf register map: address register at BaseAddr, data register at BaseAddr+1. Both are word addresses.

Parameters:
- BaseAddr, 'h0188, word address of the ParamIntf address register.
- AutoInc, 1, 1 = slave post-increments the param address on every data access; 0 = the master rewrites the address register before every word.
- CountWidth, 4, width of the burst-length input.

Ports:
- Clk_i  in  1  clock
- Reset_i  in  1  synchronous, active-high reset
- Start_i  in  1  start-burst strobe; sampled only in IDLE
- Read_i  in  1  burst direction, sampled with Start_i: 1 = read, 0 = write
- ParamAddr_i  in  16  first param address, sampled with Start_i
- Count_i  in  CountWidth  number of words, sampled with Start_i
- WrData_i  in  16  write word
- WrValid_i  in  1  write word available
- WrReady_o  out  1  write word consumed this cycle
- RdData_o  out  16  read word
- RdValid_o  out  1  one-cycle pulse, RdData_o valid
- Busy_o  out  1  burst in progress
- Done_o  out  1  one-cycle pulse at end of burst
- PerAddr_o  out  14  bus word address
- PerDOut_o  out  16  bus write data
- PerWr_o  out  2  byte write enables; 2'b11 = word write, 2'b00 = read
- PerEn_o  out  1  bus access strobe
- PerDIn_i  in  16  bus read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: single clock Clk_i. Reset_i is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset mid-burst: the cycle after Reset_i is sampled, all bus outputs are 0 and the state is IDLE. No Done_o pulse. A partial burst is abandoned.
- All outputs are registered. A bus access is exactly one cycle with PerEn_o=1. PerAddr_o, PerDOut_o and PerWr_o are valid only while PerEn_o=1 and are 0 otherwise.
- Address field: PerDOut_o carries ParamAddr zero-extended to 16 bits on address-register writes.
- States: IDLE, SET_ADDR, WAIT_WR, WRITE, READ, READ_CAP, DONE.
- IDLE:
  - Start_i=1 and Count_i!=0: latch inputs, Busy_o=1, go to SET_ADDR.
  - Start_i=1 and Count_i=0: go to DONE directly, no bus activity.
  - Start_i while Busy_o=1 is ignored.
- SET_ADDR: bus write to BaseAddr with the current param address, then:
  - write burst: go to WAIT_WR;
  - read burst: go to READ.
- WAIT_WR: wait for WrValid_i=1, then go to WRITE.
- WRITE: bus write of WrData_i to BaseAddr+1. WrReady_o=1 in the same cycle. Decrement the remaining count and increment the local param address.
  - remaining = 0: go to DONE;
  - AutoInc=1: go to WAIT_WR;
  - AutoInc=0: go to SET_ADDR.
- READ: bus read strobe at BaseAddr+1 (cycle T).
- READ_CAP (cycle T+1): register PerDIn_i. RdData_o/RdValid_o are presented in T+2. Decrement the count and increment the address.
  - remaining = 0: go to DONE;
  - AutoInc=1: go to READ;
  - AutoInc=0: go to SET_ADDR.
  - This gives one word per 2 cycles with AutoInc=1, or per 3 cycles with AutoInc=0.
- DONE: Done_o=1 for one cycle, Busy_o falls in the same cycle, go to IDLE.
  - Read bursts: the final RdValid_o pulse coincides with the Done_o pulse.
- Read latency, strobe to RdValid_o: 2 cycles.
- WrValid_i may stay low indefinitely. The block stalls in WAIT_WR with PerEn_o=0.
- Param address increments modulo 2^16.
- Count uses full CountWidth. The maximum is 2^CountWidth-1 words.

Test Plan:
- Write burst, AutoInc=1, ParamAddr=2, Count=3, data 'h1111/'h2222/'h3333 always valid -> bus sequence: wr 'h0188 ← 'h0002, then wr 'h0189 ← 'h1111, 'h2222, 'h3333. Exactly 3 WrReady_o pulses. Done_o one cycle after the last write.
- Same burst with AutoInc=0 -> alternating address/data writes: 'h0188←2, 'h0189←'h1111, 'h0188←3, 'h0189←'h2222, 'h0188←4, 'h0189←'h3333.
- Read burst, ParamAddr=0, Count=2, slave returns 'h00A5 then 'h1234 -> RdValid_o pulses with RdData_o='h00A5, then 'h1234, each 2 cycles after its PerEn_o read strobe with PerWr_o=00. The final pulse coincides with Done_o.
- WrValid_i held low 5 cycles mid-burst -> PerEn_o=0 throughout the stall. The burst resumes and completes correctly.
- Start_i with Count_i=0 -> Done_o pulse, PerEn_o never asserted. Start_i pulsed while Busy_o=1 -> ignored, bus trace unchanged.
- Reset_i asserted during the second data write of a 3-word burst -> all outputs 0 the next cycle, no Done_o. A new Start_i then runs a clean full burst.
